// File: rtl/user_obi_sram_rsp_if.sv
// OBI subordinate-side bus bundle: request channel (req/addr/wdata/we/id),
// combinational grant, and the registered response channel (rvalid/rdata/rid/err).
interface user_obi_sram_rsp_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
);
    logic                  sbr_obi_req_i;
    logic [ADDR_WIDTH-1:0] sbr_obi_addr_i;
    logic [DATA_WIDTH-1:0] sbr_obi_wdata_i;
    logic                  sbr_obi_we_i;
    logic [ID_WIDTH-1:0]   sbr_obi_id_i;
    logic                  sbr_obi_gnt_o;
    logic                  sbr_obi_rvalid_o;
    logic [DATA_WIDTH-1:0] sbr_obi_rdata_o;
    logic [ID_WIDTH-1:0]   sbr_obi_rid_o;
    logic                  sbr_obi_err_o;

    modport master (
        output sbr_obi_req_i, sbr_obi_addr_i, sbr_obi_wdata_i,
        output sbr_obi_we_i, sbr_obi_id_i,
        input  sbr_obi_gnt_o, sbr_obi_rvalid_o, sbr_obi_rdata_o,
        input  sbr_obi_rid_o, sbr_obi_err_o
    );

    modport slave (
        input  sbr_obi_req_i, sbr_obi_addr_i, sbr_obi_wdata_i,
        input  sbr_obi_we_i, sbr_obi_id_i,
        output sbr_obi_gnt_o, sbr_obi_rvalid_o, sbr_obi_rdata_o,
        output sbr_obi_rid_o, sbr_obi_err_o
    );
endinterface

// File: rtl/user_obi_sram_rsp.sv
// OBI SRAM responder: word memory, programmable grant stall, saturating counters.
// Ports: clk_i, rst_ni (async low), sbr (slave bus), rd_cnt_o / wr_cnt_o.
module user_obi_sram_rsp #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned NUM_WORDS  = 256,
    parameter int unsigned GNT_WAIT   = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    user_obi_sram_rsp_if.slave       sbr,
    output logic [15:0]              rd_cnt_o,
    output logic [15:0]              wr_cnt_o
);
    localparam int unsigned AW = $clog2(NUM_WORDS);
    localparam logic [3:0]  GW = 4'(GNT_WAIT);

    typedef enum logic {
        IDLE,
        STALL
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            wait_q, wait_d;
    logic                  gnt;
    logic                  fire;
    logic                  req_err;
    logic [ADDR_WIDTH-3:0] idx;
    logic [AW-1:0]         widx;

    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic                  err_q;
    logic [15:0]           rd_cnt_q, wr_cnt_q;

    assign idx     = sbr.sbr_obi_addr_i[ADDR_WIDTH-1:2];
    assign widx    = idx[AW-1:0];
    assign req_err = (sbr.sbr_obi_addr_i[1:0] != 2'b00)
                   || (32'(idx) >= NUM_WORDS);
    assign fire    = sbr.sbr_obi_req_i && gnt;

    // Grant FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Grant FSM: next state
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            IDLE: begin
                if (sbr.sbr_obi_req_i && (GNT_WAIT != 0)) begin
                    state_d = STALL;
                    wait_d  = 4'd1;
                end
            end
            STALL: begin
                // A withdrawn request abandons the stall without a grant
                if (!sbr.sbr_obi_req_i || (wait_q == GW)) begin
                    state_d = IDLE;
                    wait_d  = 4'd0;
                end else begin
                    wait_d  = wait_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                wait_d  = 4'd0;
            end
        endcase
    end

    // Grant FSM: outputs
    always_comb begin
        gnt = 1'b0;
        unique case (state_q)
            IDLE:    gnt = sbr.sbr_obi_req_i && (GNT_WAIT == 0);
            STALL:   gnt = sbr.sbr_obi_req_i && (wait_q == GW);
            default: gnt = 1'b0;
        endcase
    end

    // Memory has no reset so contents survive a reset pulse
    always_ff @(posedge clk_i) begin
        if (fire && sbr.sbr_obi_we_i && !req_err) begin
            mem_q[widx] <= sbr.sbr_obi_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= fire;
            if (fire) begin
                rid_q   <= sbr.sbr_obi_id_i;
                err_q   <= req_err;
                rdata_q <= (sbr.sbr_obi_we_i || req_err) ? '0 : mem_q[widx];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else if (fire) begin
            if (sbr.sbr_obi_we_i) begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            end else begin
                if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign sbr.sbr_obi_gnt_o    = gnt;
    assign sbr.sbr_obi_rvalid_o = rvalid_q;
    assign sbr.sbr_obi_rdata_o  = rdata_q;
    assign sbr.sbr_obi_rid_o    = rid_q;
    assign sbr.sbr_obi_err_o    = err_q;
    assign rd_cnt_o             = rd_cnt_q;
    assign wr_cnt_o             = wr_cnt_q;
endmodule

// File: tb/tb_user_obi_sram_rsp.sv
// Bench for user_obi_sram_rsp: a zero-wait instance and a GNT_WAIT=3 instance
// driven with directed and random traffic against a behavioural memory model.
module tb_user_obi_sram_rsp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] rd0, wr0, rd1, wr1;
    int          ncmp = 0;
    int          nbad = 0;

    logic [31:0] m0 [256];
    int          rd_n = 0, wr_n = 0;
    logic [31:0] last_rdata = '0;
    logic [3:0]  last_rid = '0;
    logic        last_err = 1'b0;

    always #5 clk = ~clk;

    user_obi_sram_rsp_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .ID_WIDTH(4)) bus0 ();
    user_obi_sram_rsp_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .ID_WIDTH(4)) bus1 ();

    user_obi_sram_rsp #(.GNT_WAIT(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .sbr(bus0.slave),
        .rd_cnt_o(rd0), .wr_cnt_o(wr0)
    );

    user_obi_sram_rsp #(.GNT_WAIT(3)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .sbr(bus1.slave),
        .rd_cnt_o(rd1), .wr_cnt_o(wr1)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_err(input logic [15:0] a);
        return (a[1:0] != 2'b00) || (a >= 16'h0400);
    endfunction

    function automatic logic [15:0] sat(input int n);
        return (n > 65535) ? 16'hFFFF : 16'(n);
    endfunction

    // One cycle on the zero-wait instance, checked against the model
    task automatic op0(input logic req, input logic we, input logic [15:0] addr,
                       input logic [31:0] wd, input logic [3:0] id);
        logic        e;
        logic [31:0] rexp;
        @(negedge clk);
        bus0.sbr_obi_req_i   = req;
        bus0.sbr_obi_we_i    = we;
        bus0.sbr_obi_addr_i  = addr;
        bus0.sbr_obi_wdata_i = wd;
        bus0.sbr_obi_id_i    = id;
        #1 check("gnt0", 32'(bus0.sbr_obi_gnt_o), 32'(req));
        e = is_err(addr);
        if (req) begin
            rexp = (we || e) ? 32'h0 : m0[addr[9:2]];
            if (we && !e) m0[addr[9:2]] = wd;
            if (we) wr_n++;
            else rd_n++;
            last_rdata = rexp;
            last_rid   = id;
            last_err   = e;
        end
        @(posedge clk);
        #1;
        check("rvalid0", 32'(bus0.sbr_obi_rvalid_o), 32'(req));
        check("rdata0", bus0.sbr_obi_rdata_o, last_rdata);
        check("rid0", 32'(bus0.sbr_obi_rid_o), 32'(last_rid));
        check("err0", 32'(bus0.sbr_obi_err_o), 32'(last_err));
        check("rd_cnt0", 32'(rd0), 32'(sat(rd_n)));
        check("wr_cnt0", 32'(wr0), 32'(sat(wr_n)));
    endtask

    // Hold a request on the stalled instance; id and wdata change every
    // cycle so the response shows which cycle's values were taken.
    task automatic req1(input logic we, input logic [15:0] addr,
                        input logic [31:0] base, output int gcyc);
        gcyc = 0;
        for (int i = 1; i <= 10 && gcyc == 0; i++) begin
            @(negedge clk);
            bus1.sbr_obi_req_i   = 1'b1;
            bus1.sbr_obi_we_i    = we;
            bus1.sbr_obi_addr_i  = addr;
            bus1.sbr_obi_wdata_i = base + 32'(i);
            bus1.sbr_obi_id_i    = 4'(i);
            #1 if (bus1.sbr_obi_gnt_o) gcyc = i;
            @(posedge clk);
            #1 check("rvalid1", 32'(bus1.sbr_obi_rvalid_o), 32'(gcyc == i));
        end
        check("stall_gnt_cycle", 32'(gcyc), 32'd4);
    endtask

    initial begin
        int          g;
        logic [15:0] a;
        bus0.sbr_obi_req_i = 1'b0; bus0.sbr_obi_we_i = 1'b0;
        bus0.sbr_obi_addr_i = '0; bus0.sbr_obi_wdata_i = '0; bus0.sbr_obi_id_i = '0;
        bus1.sbr_obi_req_i = 1'b0; bus1.sbr_obi_we_i = 1'b0;
        bus1.sbr_obi_addr_i = '0; bus1.sbr_obi_wdata_i = '0; bus1.sbr_obi_id_i = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_rvalid", 32'(bus0.sbr_obi_rvalid_o), 32'd0);
        check("rst_rdata", bus0.sbr_obi_rdata_o, 32'd0);
        check("rst_rid", 32'(bus0.sbr_obi_rid_o), 32'd0);
        check("rst_err", 32'(bus0.sbr_obi_err_o), 32'd0);
        check("rst_rd_cnt", 32'(rd0), 32'd0);
        check("rst_wr_cnt", 32'(wr0), 32'd0);
        check("rst_gnt_noreq", 32'(bus0.sbr_obi_gnt_o), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Basic write then read
        op0(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 4'd3);
        op0(1'b1, 1'b0, 16'h0010, 32'h0, 4'd5);
        op0(1'b0, 1'b0, 16'h0000, 32'h0, 4'd0);

        // Back-to-back writes then reads
        op0(1'b1, 1'b1, 16'h0000, 32'h11, 4'd1);
        op0(1'b1, 1'b1, 16'h0004, 32'h22, 4'd2);
        op0(1'b1, 1'b1, 16'h0008, 32'h33, 4'd3);
        op0(1'b1, 1'b0, 16'h0000, 32'h0, 4'd4);
        op0(1'b1, 1'b0, 16'h0004, 32'h0, 4'd5);
        op0(1'b1, 1'b0, 16'h0008, 32'h0, 4'd6);
        // Read-after-write in consecutive cycles
        op0(1'b1, 1'b1, 16'h000C, 32'hA5A5_0001, 4'd7);
        op0(1'b1, 1'b0, 16'h000C, 32'h0, 4'd8);

        // Error paths
        op0(1'b1, 1'b0, 16'h0400, 32'h0, 4'd9);
        op0(1'b1, 1'b1, 16'h0002, 32'h55, 4'd10);
        op0(1'b1, 1'b0, 16'h0000, 32'h0, 4'd11);
        op0(1'b0, 1'b0, 16'h0000, 32'h0, 4'd0);

        // Stalled instance: grant in cycle 4 with that cycle's id/wdata
        req1(1'b1, 16'h0020, 32'hCAFE_0000, g);
        check("stall_rid", 32'(bus1.sbr_obi_rid_o), 32'(g));
        check("stall_werr", 32'(bus1.sbr_obi_err_o), 32'd0);
        @(negedge clk) bus1.sbr_obi_req_i = 1'b0;
        @(posedge clk);
        #1 check("stall_rvalid_drop", 32'(bus1.sbr_obi_rvalid_o), 32'd0);

        // Withdrawn request: no grant, no response, stall restarts from scratch
        @(negedge clk);
        bus1.sbr_obi_req_i = 1'b1; bus1.sbr_obi_we_i = 1'b0;
        #1 check("abort_gnt_c1", 32'(bus1.sbr_obi_gnt_o), 32'd0);
        @(posedge clk);
        #1 check("abort_rvalid_c1", 32'(bus1.sbr_obi_rvalid_o), 32'd0);
        @(negedge clk) bus1.sbr_obi_req_i = 1'b0;
        #1 check("abort_gnt_c2", 32'(bus1.sbr_obi_gnt_o), 32'd0);
        @(posedge clk);
        #1 check("abort_rvalid_c2", 32'(bus1.sbr_obi_rvalid_o), 32'd0);
        req1(1'b0, 16'h0020, 32'h0, g);
        check("stall_rdata", bus1.sbr_obi_rdata_o, 32'hCAFE_0004);
        check("stall_rd_cnt", 32'(rd1), 32'd1);
        check("stall_wr_cnt", 32'(wr1), 32'd1);
        @(negedge clk) bus1.sbr_obi_req_i = 1'b0;

        // Fill every word, then random traffic
        for (int i = 0; i < 256; i++)
            op0(1'b1, 1'b1, 16'(i * 4), $urandom, 4'(i));
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) a = 16'($urandom);
            else a = {6'b0, 8'($urandom), 2'b00};
            op0($urandom_range(0, 3) != 0, 1'($urandom), a, $urandom,
                4'($urandom));
        end

        // Drive the read counter past saturation
        while (rd_n < 65540)
            op0(1'b1, 1'b0, {6'b0, 8'($urandom), 2'b00}, 32'h0, 4'($urandom));
        check("rd_sat", 32'(rd0), 32'h0000FFFF);

        // Reset in the cycle after a grant; memory must survive
        op0(1'b1, 1'b1, 16'h0040, 32'h1234_5678, 4'd12);
        op0(1'b1, 1'b0, 16'h0040, 32'h0, 4'd13);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rvalid", 32'(bus0.sbr_obi_rvalid_o), 32'd0);
        check("mid_rst_rd_cnt", 32'(rd0), 32'd0);
        check("mid_rst_wr_cnt", 32'(wr0), 32'd0);
        check("mid_rst_rdata", bus0.sbr_obi_rdata_o, 32'd0);
        bus0.sbr_obi_req_i = 1'b0;
        rd_n = 0; wr_n = 0;
        last_rdata = '0; last_rid = '0; last_err = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        op0(1'b1, 1'b0, 16'h0040, 32'h0, 4'd14);
        op0(1'b1, 1'b0, 16'h0000, 32'h0, 4'd15);
        op0(1'b0, 1'b0, 16'h0000, 32'h0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
